ss_rrat_ckpt: RTL and testbench

Parametrised retirement register alias table (RRAT) for the superscalar back end. It records the committed architectural-to-physical mapping for up to `WIDTH` retirements per cycle and returns each overwritten physical tag to the freelist. It serves bypassed read ports for store/commit paths. On a branch-mispredict flush it streams the committed map to the front-end RAT over several cycles through a copy-out state machine.

---
 rtl/ss_rrat_ckpt.sv | 126 ++++++++++++
 tb/tb_ss_rrat_ckpt.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/ss_rrat_ckpt.sv
// Retirement RAT: commits up to WIDTH arch->phys mappings per cycle, frees overwritten tags, copies map out on flush.
// Latency: map/free registered one cycle after retire; rd_tag/rrat_table bypass same cycle; copy takes NBEATS cycles.
// Backpressure: retire_ready drops for the whole copy-out; retires and flushes offered while busy are discarded.
module ss_rrat_ckpt #(
    parameter int WIDTH      = 2,
    parameter int ARCH_REGS  = 32,
    parameter int PRF_SIZE   = 64,
    parameter int NUM_RD     = 1,
    parameter int COPY_LANES = 8,
    localparam int AW = $clog2(ARCH_REGS),
    localparam int PW = $clog2(PRF_SIZE)
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic [WIDTH-1:0]                    retire_en,
    input  logic [WIDTH-1:0][AW-1:0]            retire_dest,
    input  logic [WIDTH-1:0][PW-1:0]            retire_tag,
    output logic                                retire_ready,
    output logic [WIDTH-1:0]                    free_valid,
    output logic [WIDTH-1:0][PW-1:0]            free_tag,
    input  logic [NUM_RD-1:0][AW-1:0]           rd_idx,
    output logic [NUM_RD-1:0][PW-1:0]           rd_tag,
    output logic [ARCH_REGS-1:0][PW-1:0]        rrat_table,
    input  logic                                flush,
    output logic                                busy,
    output logic                                copy_valid,
    output logic [AW-1:0]                       copy_base,
    output logic [COPY_LANES-1:0][PW-1:0]       copy_tags,
    output logic                                copy_done
);
    localparam int NBEATS = (ARCH_REGS + COPY_LANES - 1) / COPY_LANES;
    localparam int BW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(NBEATS - 1);

    typedef enum logic {IDLE = 1'b0, COPY = 1'b1} state_t;

    state_t                     state, state_nxt;
    logic [BW-1:0]              beat, beat_nxt;
    logic [PW-1:0]              map     [ARCH_REGS];
    logic [PW-1:0]              map_nxt [ARCH_REGS];
    logic [WIDTH-1:0]           fire;
    logic [WIDTH-1:0][PW-1:0]   old_tag;

    assign busy         = (state == COPY);
    assign retire_ready = !busy;

    // Slots applied in order so a later slot sees (and frees) an earlier slot's tag.
    always_comb begin
        map_nxt = map;
        fire    = '0;
        old_tag = '0;
        for (int h = 0; h < WIDTH; h++) begin
            fire[h] = retire_en[h] && !busy && (retire_dest[h] != '0);
            if (fire[h]) begin
                old_tag[h]              = map_nxt[retire_dest[h]];
                map_nxt[retire_dest[h]] = retire_tag[h];
            end
        end
    end

    always_comb begin
        rrat_table = '0;
        rd_tag     = '0;
        for (int i = 0; i < ARCH_REGS; i++) rrat_table[i] = map_nxt[i];
        for (int r = 0; r < NUM_RD; r++) rd_tag[r] = map_nxt[rd_idx[r]];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < ARCH_REGS; i++) map[i] <= PW'(i);
            free_valid <= '0;
            free_tag   <= '0;
        end else begin
            map        <= map_nxt;
            free_valid <= fire;
            free_tag   <= old_tag;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            beat  <= '0;
        end else begin
            state <= state_nxt;
            beat  <= beat_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        beat_nxt  = beat;
        case (state)
            IDLE: if (flush) begin
                state_nxt = COPY;
                beat_nxt  = '0;
            end
            COPY: begin
                beat_nxt = beat + 1'b1;
                if (beat == LAST_BEAT) begin
                    state_nxt = IDLE;
                    beat_nxt  = '0;
                end
            end
        endcase
    end

    // Retires are blocked during COPY, so map is a stable snapshot for every beat.
    always_comb begin
        int idx;
        idx        = 0;
        copy_valid = 1'b0;
        copy_done  = 1'b0;
        copy_base  = '0;
        copy_tags  = '0;
        if (state == COPY) begin
            copy_valid = 1'b1;
            copy_done  = (beat == LAST_BEAT);
            copy_base  = AW'(int'(beat) * COPY_LANES);
            for (int k = 0; k < COPY_LANES; k++) begin
                idx = int'(beat) * COPY_LANES + k;
                if (idx < ARCH_REGS) copy_tags[k] = map[idx[AW-1:0]];
            end
        end
    end
endmodule

// File: tb/tb_ss_rrat_ckpt.sv
// Scoreboard bench for ss_rrat_ckpt: stimulus queues expected frees/beats, a negedge monitor pops and compares.
module tb_ss_rrat_ckpt;
    localparam int WIDTH = 2, AW = 5, PW = 6, NUM_RD = 1, LANES = 8, NB = 4, AR = 32;

    logic                          clock, reset;
    logic [WIDTH-1:0]              retire_en;
    logic [WIDTH-1:0][AW-1:0]      retire_dest;
    logic [WIDTH-1:0][PW-1:0]      retire_tag;
    logic                          retire_ready;
    logic [WIDTH-1:0]              free_valid;
    logic [WIDTH-1:0][PW-1:0]      free_tag;
    logic [NUM_RD-1:0][AW-1:0]     rd_idx;
    logic [NUM_RD-1:0][PW-1:0]     rd_tag;
    logic [AR-1:0][PW-1:0]         rrat_table;
    logic                          flush, busy, copy_valid, copy_done;
    logic [AW-1:0]                 copy_base;
    logic [LANES-1:0][PW-1:0]      copy_tags;

    ss_rrat_ckpt dut (
        .clock(clock), .reset(reset),
        .retire_en(retire_en), .retire_dest(retire_dest), .retire_tag(retire_tag),
        .retire_ready(retire_ready), .free_valid(free_valid), .free_tag(free_tag),
        .rd_idx(rd_idx), .rd_tag(rd_tag), .rrat_table(rrat_table),
        .flush(flush), .busy(busy), .copy_valid(copy_valid), .copy_base(copy_base),
        .copy_tags(copy_tags), .copy_done(copy_done)
    );

    typedef struct { int slot; logic [PW-1:0] tag; } free_exp_t;
    typedef struct { logic [AW-1:0] base; logic [LANES-1:0][PW-1:0] tags; logic done; } beat_exp_t;

    free_exp_t     free_q[$];
    beat_exp_t     beat_q[$];
    int            checks = 0;
    int            errors = 0;
    logic [PW-1:0] mdl [AR];

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        retire_en   = '0;
        retire_dest = '0;
        retire_tag  = '0;
        flush       = 1'b0;
    endtask

    task automatic expect_free(input int slot, input int tag);
        free_q.push_back('{slot: slot, tag: PW'(tag)});
    endtask

    task automatic push_beats(input int n);
        beat_exp_t be;
        for (int b = 0; b < n; b++) begin
            be.base = AW'(b * LANES);
            for (int k = 0; k < LANES; k++) be.tags[k] = mdl[b * LANES + k];
            be.done = (b == NB - 1);
            beat_q.push_back(be);
        end
    endtask

    always @(negedge clock) begin
        free_exp_t fe;
        beat_exp_t be;
        for (int h = 0; h < WIDTH; h++) begin
            if (free_valid[h] === 1'b1) begin
                if (free_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL free_unexpected: slot %0d tag %0d, none expected", h, free_tag[h]);
                end else begin
                    fe = free_q.pop_front();
                    chk("free_slot", 64'(h), 64'(fe.slot));
                    chk("free_tag", 64'(free_tag[h]), 64'(fe.tag));
                end
            end
        end
        if (copy_valid === 1'b1) begin
            if (beat_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL beat_unexpected: base %0d, none expected", copy_base);
            end else begin
                be = beat_q.pop_front();
                chk("copy_base", 64'(copy_base), 64'(be.base));
                chk("copy_tags", 64'(copy_tags), 64'(be.tags));
                chk("copy_done", 64'(copy_done), 64'(be.done));
                chk("copy_rdy_low", 64'(retire_ready), 64'd0);
            end
        end else if (copy_done === 1'b1) begin
            checks++;
            errors++;
            $display("FAIL copy_done_stray: got 1, expected 0 outside copy");
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        clock  = 1'b0;
        reset  = 1'b1;
        rd_idx = '0;
        idle_inputs();
        for (int i = 0; i < AR; i++) mdl[i] = PW'(i);
        step();
        step();
        reset = 1'b0;
        rd_idx[0] = 5;
        @(negedge clock);
        chk("rst_rd5", 64'(rd_tag[0]), 64'd5);
        chk("rst_tbl31", 64'(rrat_table[31]), 64'd31);
        chk("rst_free_valid", 64'(free_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_ready", 64'(retire_ready), 64'd1);
        chk("rst_copy_valid", 64'(copy_valid), 64'd0);
        chk("rst_copy_tags", 64'(copy_tags), 64'd0);

        // single retire, same-cycle bypass
        step();
        retire_en = 2'b01; retire_dest[0] = 5'd3; retire_tag[0] = 6'd40; rd_idx[0] = 3;
        expect_free(0, 3); mdl[3] = 6'd40;
        @(negedge clock);
        chk("bypass_rd3", 64'(rd_tag[0]), 64'd40);
        chk("bypass_tbl3", 64'(rrat_table[3]), 64'd40);
        step(); idle_inputs();
        @(negedge clock);
        chk("stored_rd3", 64'(rd_tag[0]), 64'd40);

        // same-dest collision: later slot wins and frees the earlier slot's tag
        step();
        retire_en = 2'b11; retire_dest[0] = 5'd7; retire_tag[0] = 6'd41;
        retire_dest[1] = 5'd7; retire_tag[1] = 6'd42; rd_idx[0] = 7;
        expect_free(0, 7); expect_free(1, 41); mdl[7] = 6'd42;
        @(negedge clock);
        chk("collide_bypass7", 64'(rd_tag[0]), 64'd42);
        step(); idle_inputs();
        @(negedge clock);
        chk("collide_stored7", 64'(rd_tag[0]), 64'd42);

        // two distinct dests, then a slot-1-only retire
        step();
        retire_en = 2'b11; retire_dest[0] = 5'd3; retire_tag[0] = 6'd43;
        retire_dest[1] = 5'd5; retire_tag[1] = 6'd44; rd_idx[0] = 5;
        expect_free(0, 40); expect_free(1, 5); mdl[3] = 6'd43; mdl[5] = 6'd44;
        @(negedge clock);
        chk("pair_bypass5", 64'(rd_tag[0]), 64'd44);
        chk("pair_tbl3", 64'(rrat_table[3]), 64'd43);
        step();
        idle_inputs();
        retire_en = 2'b10; retire_dest[1] = 5'd12; retire_tag[1] = 6'd45; rd_idx[0] = 12;
        expect_free(1, 12); mdl[12] = 6'd45;
        @(negedge clock);
        chk("slot1_bypass12", 64'(rd_tag[0]), 64'd45);

        // dest 0 is hardwired and frees nothing
        step();
        idle_inputs();
        retire_en = 2'b01; retire_dest[0] = 5'd0; retire_tag[0] = 6'd50; rd_idx[0] = 0;
        @(negedge clock);
        chk("dest0_bypass", 64'(rd_tag[0]), 64'd0);
        step(); idle_inputs();
        @(negedge clock);
        chk("dest0_no_free", 64'(free_valid), 64'd0);
        chk("dest0_map0", 64'(rd_tag[0]), 64'd0);

        // flush with a same-cycle retire: snapshot must include tag 60 at index 9
        step();
        flush = 1'b1; retire_en = 2'b01; retire_dest[0] = 5'd9; retire_tag[0] = 6'd60; rd_idx[0] = 9;
        expect_free(0, 9); mdl[9] = 6'd60;
        push_beats(NB);
        @(negedge clock);
        chk("flush_bypass9", 64'(rd_tag[0]), 64'd60);
        step(); idle_inputs();
        @(negedge clock);
        chk("copy1_busy", 64'(busy), 64'd1);
        step();
        $display("NOTE protocol error injected: retire and flush offered while busy");
        flush = 1'b1; retire_en = 2'b01; retire_dest[0] = 5'd10; retire_tag[0] = 6'd61; rd_idx[0] = 10;
        @(negedge clock);
        chk("busy_no_bypass10", 64'(rd_tag[0]), 64'd10);
        chk("busy_ready_low", 64'(retire_ready), 64'd0);
        step(); idle_inputs();
        @(negedge clock);
        chk("busy_retire_dropped", 64'(free_valid), 64'd0);
        step();
        @(negedge clock);
        chk("copy4_busy", 64'(busy), 64'd1);
        step();
        @(negedge clock);
        chk("post_copy_busy", 64'(busy), 64'd0);
        chk("post_copy_ready", 64'(retire_ready), 64'd1);
        chk("post_copy_valid", 64'(copy_valid), 64'd0);
        chk("busy_retire_map10", 64'(rd_tag[0]), 64'd10);

        // second flush aborted by reset during its second beat
        step();
        flush = 1'b1;
        push_beats(2);
        step(); idle_inputs();
        step(); reset = 1'b1;
        step(); reset = 1'b0; rd_idx[0] = 9;
        @(negedge clock);
        chk("abort_copy_valid", 64'(copy_valid), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_ready", 64'(retire_ready), 64'd1);
        chk("abort_copy_base", 64'(copy_base), 64'd0);
        chk("abort_copy_tags", 64'(copy_tags), 64'd0);
        chk("abort_free_valid", 64'(free_valid), 64'd0);
        chk("abort_rd9", 64'(rd_tag[0]), 64'd9);
        chk("abort_tbl3", 64'(rrat_table[3]), 64'd3);
        chk("abort_tbl7", 64'(rrat_table[7]), 64'd7);

        step();
        step();
        @(negedge clock);
        chk("free_q_drained", 64'(free_q.size()), 64'd0);
        chk("beat_q_drained", 64'(beat_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
